// File: rtl/lcd_win_pkg.sv
// Shared opcodes and controller states for the image-window controller.
package lcd_win_pkg;

  localparam logic [3:0] CMD_WRITE    = 4'h0;
  localparam logic [3:0] CMD_UP       = 4'h1;
  localparam logic [3:0] CMD_DOWN     = 4'h2;
  localparam logic [3:0] CMD_LEFT     = 4'h3;
  localparam logic [3:0] CMD_RIGHT    = 4'h4;
  localparam logic [3:0] CMD_MAX      = 4'h5;
  localparam logic [3:0] CMD_MIN      = 4'h6;
  localparam logic [3:0] CMD_AVG      = 4'h7;
  localparam logic [3:0] CMD_CCW      = 4'h8;
  localparam logic [3:0] CMD_CW       = 4'h9;
  localparam logic [3:0] CMD_MIRX     = 4'hA;
  localparam logic [3:0] CMD_MIRY     = 4'hB;
  localparam logic [3:0] CMD_INVERT   = 4'hC;
  localparam logic [3:0] CMD_RECENTRE = 4'hD;

  typedef enum logic [2:0] {LOAD, IDLE, EXEC, WRITE, DONE} state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: computes the four replacement pixels for an opcode.
// Zero latency; non-window opcodes pass the window through unchanged.
module lcd_win_alu
  import lcd_win_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] tl,
  input  logic [DATA_W-1:0] tr,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] br,
  output logic [DATA_W-1:0] new_tl,
  output logic [DATA_W-1:0] new_tr,
  output logic [DATA_W-1:0] new_bl,
  output logic [DATA_W-1:0] new_br
);

  logic [DATA_W-1:0] max_t, max_b, max_all;
  logic [DATA_W-1:0] min_t, min_b, min_all;
  logic [DATA_W+1:0] sum;

  always_comb begin
    max_t   = (tl > tr) ? tl : tr;
    max_b   = (bl > br) ? bl : br;
    max_all = (max_t > max_b) ? max_t : max_b;
    min_t   = (tl < tr) ? tl : tr;
    min_b   = (bl < br) ? bl : br;
    min_all = (min_t < min_b) ? min_t : min_b;
    // Two guard bits hold the sum of four pixels without overflow.
    sum     = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};

    new_tl = tl;
    new_tr = tr;
    new_bl = bl;
    new_br = br;
    case (op)
      CMD_MAX: begin
        new_tl = max_all; new_tr = max_all; new_bl = max_all; new_br = max_all;
      end
      CMD_MIN: begin
        new_tl = min_all; new_tr = min_all; new_bl = min_all; new_br = min_all;
      end
      CMD_AVG: begin
        new_tl = sum[DATA_W+1:2]; new_tr = sum[DATA_W+1:2];
        new_bl = sum[DATA_W+1:2]; new_br = sum[DATA_W+1:2];
      end
      CMD_CCW: begin
        new_tl = tr; new_tr = br; new_bl = tl; new_br = bl;
      end
      CMD_CW: begin
        new_tl = bl; new_tr = tl; new_bl = br; new_br = tr;
      end
      CMD_MIRX: begin
        new_tl = bl; new_tr = br; new_bl = tl; new_br = tr;
      end
      CMD_MIRY: begin
        new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
      end
      CMD_INVERT: begin
        new_tl = ~tl; new_tr = ~tr; new_bl = ~bl; new_br = ~br;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_win_ctrl.sv
// Image-window controller: loads IROM into a pixel file, applies window commands, writes back to IRAM.
// Load takes N+1 cycles, window/shift commands 1 cycle, write N+1 cycles; commands are dropped while busy.
module lcd_win_ctrl
  import lcd_win_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       cmd,
  input  logic                             cmd_valid,
  output logic                             IROM_rd,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   IROM_A,
  input  logic [DATA_W-1:0]                IROM_Q,
  output logic                             IRAM_valid,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   IRAM_A,
  output logic [DATA_W-1:0]                IRAM_D,
  output logic                             busy,
  output logic                             done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t            state, state_nxt;
  logic [XW-1:0]     px, px_m1;
  logic [YW-1:0]     py, py_m1;
  logic [3:0]        op;
  logic [DATA_W-1:0] pix [N];
  logic [AW-1:0]     i_tl, i_tr, i_bl, i_br;
  logic [DATA_W-1:0] new_tl, new_tr, new_bl, new_br;

  // Power-of-two dimensions make the linear index a plain {y, x} concatenation.
  assign px_m1 = px - XW'(1);
  assign py_m1 = py - YW'(1);
  assign i_tl  = {py_m1, px_m1};
  assign i_tr  = {py_m1, px};
  assign i_bl  = {py, px_m1};
  assign i_br  = {py, px};

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign IRAM_valid = (state == WRITE);

  lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .tl     (pix[i_tl]),
    .tr     (pix[i_tr]),
    .bl     (pix[i_bl]),
    .br     (pix[i_br]),
    .new_tl (new_tl),
    .new_tr (new_tr),
    .new_bl (new_bl),
    .new_br (new_br)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (IROM_rd && IROM_A == LAST) state_nxt = IDLE;
      IDLE:    if (cmd_valid) state_nxt = (cmd == CMD_WRITE) ? WRITE : EXEC;
      EXEC:    state_nxt = IDLE;
      WRITE:   if (IRAM_A == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IROM_rd <= 1'b0;
      IROM_A  <= '0;
      IRAM_A  <= '0;
      IRAM_D  <= '0;
      px      <= XW'(IMG_W / 2);
      py      <= YW'(IMG_H / 2);
      op      <= CMD_WRITE;
    end else begin
      case (state)
        LOAD: begin
          if (!IROM_rd) begin
            IROM_rd <= 1'b1;
            IROM_A  <= '0;
          end else if (IROM_A == LAST) begin
            IROM_rd <= 1'b0;
          end else begin
            IROM_A <= IROM_A + AW'(1);
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            op <= cmd;
            if (cmd == CMD_WRITE) begin
              IRAM_A <= '0;
              IRAM_D <= pix[0];
            end
          end
        end
        EXEC: begin
          case (op)
            CMD_UP:       if (py > YW'(1)) py <= py_m1;
            CMD_DOWN:     if (py != YW'(IMG_H - 1)) py <= py + YW'(1);
            CMD_LEFT:     if (px > XW'(1)) px <= px_m1;
            CMD_RIGHT:    if (px != XW'(IMG_W - 1)) px <= px + XW'(1);
            CMD_RECENTRE: begin
              px <= XW'(IMG_W / 2);
              py <= YW'(IMG_H / 2);
            end
            default: ;
          endcase
        end
        WRITE: begin
          if (IRAM_A != LAST) begin
            IRAM_A <= IRAM_A + AW'(1);
            IRAM_D <= pix[IRAM_A + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel file has no reset: it is always refilled by LOAD before use.
  always_ff @(posedge clk) begin
    if (state == LOAD && IROM_rd) begin
      pix[IROM_A] <= IROM_Q;
    end else if (state == EXEC) begin
      pix[i_tl] <= new_tl;
      pix[i_tr] <= new_tr;
      pix[i_bl] <= new_bl;
      pix[i_br] <= new_br;
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Randomised bench for lcd_win_ctrl (8x8x8 and 16x4x10 instances) against an array-level image model.
module tb_lcd_win_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] cmd;
  logic       cv_a, cv_b;

  logic       rd_a, wv_a, busy_a, done_a;
  logic [5:0] ra_a, wa_a;
  logic [7:0] q_a = '0;
  logic [7:0] wd_a;

  logic       rd_b, wv_b, busy_b, done_b;
  logic [5:0] ra_b, wa_b;
  logic [9:0] q_b = '0;
  logic [9:0] wd_b;

  lcd_win_ctrl u_a (
    .clk(clk), .reset(rst_a), .cmd(cmd), .cmd_valid(cv_a),
    .IROM_rd(rd_a), .IROM_A(ra_a), .IROM_Q(q_a),
    .IRAM_valid(wv_a), .IRAM_A(wa_a), .IRAM_D(wd_a),
    .busy(busy_a), .done(done_a)
  );

  lcd_win_ctrl #(.IMG_W(16), .IMG_H(4), .DATA_W(10)) u_b (
    .clk(clk), .reset(rst_b), .cmd(cmd), .cmd_valid(cv_b),
    .IROM_rd(rd_b), .IROM_A(ra_b), .IROM_Q(q_b),
    .IRAM_valid(wv_b), .IRAM_A(wa_b), .IRAM_D(wd_b),
    .busy(busy_b), .done(done_b)
  );

  logic       sel = 1'b0;
  logic       c_busy, c_done, c_rd, c_wv;
  logic [5:0] c_ra, c_wa;
  logic [9:0] c_wd;
  assign c_busy = sel ? busy_b : busy_a;
  assign c_done = sel ? done_b : done_a;
  assign c_rd   = sel ? rd_b   : rd_a;
  assign c_wv   = sel ? wv_b   : wv_a;
  assign c_ra   = sel ? ra_b   : ra_a;
  assign c_wa   = sel ? wa_b   : wa_a;
  assign c_wd   = sel ? wd_b   : {2'b00, wd_a};

  int total = 0, bad = 0;
  int W = 8, H = 8, N = 64;
  logic [9:0] dmask = 10'h0FF;
  logic [9:0] rom [64];
  logic [9:0] ram [64];
  logic [9:0] img [64];
  int mx, my;
  int wr_cnt = 0, done_tot = 0, wa_base = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // ROM/RAM models plus the per-cycle write-back comparison.
  always @(negedge clk) begin
    if (rd_a) q_a <= rom[ra_a][7:0];
    if (rd_b) q_b <= rom[ra_b];
    if (c_done) done_tot++;
    if (c_wv) begin
      check("iram_write", {c_wa, c_wd}, {6'(wr_cnt - wa_base), img[c_wa]});
      ram[c_wa] = c_wd;
      wr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_cmd(input int op);
    int idx[4];
    logic [9:0] w[4], nv[4];
    int s;
    logic [9:0] m;
    idx[0] = (my - 1) * W + mx - 1; idx[1] = idx[0] + 1;
    idx[2] = idx[0] + W;            idx[3] = idx[2] + 1;
    for (int k = 0; k < 4; k++) begin w[k] = img[idx[k]]; nv[k] = w[k]; end
    s = 0;
    case (op)
      1:  my = (my > 1) ? my - 1 : 1;
      2:  my = (my < H - 1) ? my + 1 : H - 1;
      3:  mx = (mx > 1) ? mx - 1 : 1;
      4:  mx = (mx < W - 1) ? mx + 1 : W - 1;
      13: begin mx = W / 2; my = H / 2; end
      5:  begin m = w[0]; for (int k = 1; k < 4; k++) if (w[k] > m) m = w[k];
                for (int k = 0; k < 4; k++) nv[k] = m; end
      6:  begin m = w[0]; for (int k = 1; k < 4; k++) if (w[k] < m) m = w[k];
                for (int k = 0; k < 4; k++) nv[k] = m; end
      7:  begin for (int k = 0; k < 4; k++) s += int'(w[k]);
                for (int k = 0; k < 4; k++) nv[k] = 10'(s / 4); end
      8:  begin nv[0] = w[1]; nv[1] = w[3]; nv[2] = w[0]; nv[3] = w[2]; end
      9:  begin nv[0] = w[2]; nv[1] = w[0]; nv[2] = w[3]; nv[3] = w[1]; end
      10: begin nv[0] = w[2]; nv[1] = w[3]; nv[2] = w[0]; nv[3] = w[1]; end
      11: begin nv[0] = w[1]; nv[1] = w[0]; nv[2] = w[3]; nv[3] = w[2]; end
      12: for (int k = 0; k < 4; k++) nv[k] = ~w[k] & dmask;
      default: ;
    endcase
    for (int k = 0; k < 4; k++) img[idx[k]] = nv[k];
  endtask

  task automatic reload();
    int n;
    @(negedge clk);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    #2;
    check("reset_vals", {c_busy, c_done, c_rd, c_wv, c_ra, c_wa, c_wd},
          {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 10'd0});
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    @(posedge clk); #1;
    check("load_start", {c_rd, c_ra}, {1'b1, 6'd0});
    n = 1;
    while (c_busy && n < N + 20) begin @(posedge clk); #1; n++; end
    check("load_len", {c_rd, 32'(n)}, {1'b0, 32'(N + 1)});
    for (int i = 0; i < N; i++) img[i] = rom[i] & dmask;
    mx = W / 2; my = H / 2;
  endtask

  task automatic run_cmd(input logic [3:0] op, input int hold);
    int n, d0;
    @(negedge clk);
    cmd = op;
    if (sel) cv_b = 1'b1; else cv_a = 1'b1;
    wa_base = wr_cnt; d0 = done_tot;
    @(posedge clk); #1;
    check("busy_after_accept", c_busy, 1);
    n = 0;
    while (c_busy && n < N + 20) begin
      if (n >= hold - 1) begin cv_a = 1'b0; cv_b = 1'b0; end
      @(posedge clk); #1; n++;
    end
    cv_a = 1'b0; cv_b = 1'b0;
    check("busy_len", 64'(n), (op == 4'h0) ? 64'(N + 1) : 64'd1);
    model_cmd(int'(op));
    if (op == 4'h0) begin
      check("done_pulses", 64'(done_tot - d0), 64'd1);
      check("write_count", 64'(wr_cnt - wa_base), 64'(N));
    end
  endtask

  task automatic check_ram(input string nm);
    int e = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== img[i]) e++;
    check(nm, 64'(e), 64'd0);
  endtask

  task automatic check_win(input string nm, input int i0, input int i1, input int i2, input int i3,
                           input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2, input logic [9:0] e3);
    check(nm, {ram[i0], ram[i1], ram[i2], ram[i3]}, {e0, e1, e2, e3});
  endtask

  // Centre window of the 8x8 image at point (4,4): indices 27,28,35,36.
  task automatic win_case(input string nm, input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] d, input logic [3:0] op,
                          input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2, input logic [9:0] e3);
    rom[27] = a; rom[28] = b; rom[35] = c; rom[36] = d;
    reload();
    run_cmd(op, 1);
    run_cmd(4'h0, 1);
    check_win(nm, 27, 28, 35, 36, e0, e1, e2, e3);
    check_ram({nm, "_image"});
  endtask

  initial begin
    int n;
    logic [9:0] s20;
    rst_a = 1'b1; rst_b = 1'b1; cmd = 4'h0; cv_a = 1'b0; cv_b = 1'b0;
    for (int i = 0; i < 64; i++) begin rom[i] = 10'($urandom_range(0, 1023)); ram[i] = '0; end
    rom[30] = 10'd3; rom[31] = 10'd9; rom[38] = 10'd1; rom[39] = 10'd7;

    reload();
    run_cmd(4'h0, 1);
    check_ram("write_after_load");
    check("idle_after_done", {c_busy, c_done}, 2'b00);

    repeat (5) run_cmd(4'h4, 1);
    run_cmd(4'h5, 1);
    run_cmd(4'h0, 1);
    check_win("max_right_edge", 30, 31, 38, 39, 10'd9, 10'd9, 10'd9, 10'd9);
    check_ram("max_right_image");

    win_case("avg",    10'd10, 10'd11, 10'd12, 10'd14, 4'h7, 10'd11, 10'd11, 10'd11, 10'd11);
    win_case("ccw",    10'd1, 10'd2, 10'd3, 10'd4, 4'h8, 10'd2, 10'd4, 10'd1, 10'd3);
    win_case("cw",     10'd1, 10'd2, 10'd3, 10'd4, 4'h9, 10'd3, 10'd1, 10'd4, 10'd2);
    win_case("mirx",   10'd1, 10'd2, 10'd3, 10'd4, 4'hA, 10'd3, 10'd4, 10'd1, 10'd2);
    win_case("miry",   10'd1, 10'd2, 10'd3, 10'd4, 4'hB, 10'd2, 10'd1, 10'd4, 10'd3);
    win_case("invert", 10'h0F, 10'h00, 10'hFF, 10'h5A, 4'hC, 10'hF0, 10'hFF, 10'h00, 10'hA5);

    repeat (6) run_cmd(4'h1, 1);
    run_cmd(4'hD, 1);
    run_cmd(4'h5, 1);
    run_cmd(4'h0, 1);
    check_win("recentre_max", 27, 28, 35, 36, 10'hFF, 10'hFF, 10'hFF, 10'hFF);
    check_ram("recentre_image");

    // Reset in the middle of a write-back.
    for (int i = 0; i < N; i++) ram[i] = (img[i] ^ 10'h3FF) & dmask;
    s20 = ram[20];
    @(negedge clk);
    cmd = 4'h0; cv_a = 1'b1; wa_base = wr_cnt;
    @(posedge clk); #1;
    cv_a = 1'b0;
    n = 0;
    while (!(c_wv && c_wa == 6'd20) && n < 200) begin @(posedge clk); #1; n++; end
    check("reach_addr20", {c_wv, c_wa}, {1'b1, 6'd20});
    rst_a = 1'b1;
    #1;
    check("reset_drops_valid", {c_wv, c_rd, c_busy}, 3'b001);
    check("partial_ram", {ram[19], ram[20]}, {img[19], s20});
    reload();
    run_cmd(4'h0, 1);
    check_ram("write_after_reset");

    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 9) == 0) run_cmd(4'h0, 1);
      else run_cmd(4'($urandom_range(1, 15)), 1);
    end
    run_cmd(4'h0, 1);
    check_ram("random_8x8");

    // 16x4 image, 10-bit pixels; centre window indices 23,24,39,40.
    sel = 1'b1; W = 16; H = 4; N = 64; dmask = 10'h3FF;
    for (int i = 0; i < 64; i++) rom[i] = 10'($urandom_range(0, 1023));
    rom[23] = 10'h3FF; rom[24] = 10'h3FF; rom[39] = 10'h3FF; rom[40] = 10'h3FF;
    reload();
    run_cmd(4'h0, 1);
    check_ram("roundtrip_16x4");
    run_cmd(4'h7, 1);
    run_cmd(4'h0, 1);
    check_win("avg_full_scale", 23, 24, 39, 40, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    run_cmd(4'hC, 2);
    run_cmd(4'h0, 20);
    check_win("held_valid_once", 23, 24, 39, 40, 10'h000, 10'h000, 10'h000, 10'h000);
    check_ram("held_valid_image");
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) run_cmd(4'h0, 1);
      else run_cmd(4'($urandom_range(1, 15)), 1);
    end
    run_cmd(4'h0, 1);
    check_ram("random_16x4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
